// File: rtl/turbo_encoder_if.sv
// turbo_encoder_if: handshake bundle linking the bit source, the turbo encoder and the modulator.
interface turbo_encoder_if;
  logic       i_start;
  logic       i_valid;
  logic       i_bit;
  logic       o_ready;
  logic       o_valid;
  logic       i_ready;
  logic [2:0] o_code;
  logic       o_tail;
  logic       o_last;
  logic       o_done;
  modport master (
    output i_start, i_valid, i_bit, i_ready,
    input  o_ready, o_valid, o_code, o_tail, o_last, o_done
  );
  modport slave (
    input  i_start, i_valid, i_bit, i_ready,
    output o_ready, o_valid, o_code, o_tail, o_last, o_done
  );
endinterface

// File: rtl/turbo_encoder.sv
// turbo_encoder: rate-1/3 turbo encoder with two 13/15 RSC constituents and a
// (P*n+OFF) mod K interleaver; streams {p2,p1,x} beats then 6 termination beats.
module turbo_encoder #(
  parameter int K   = 16,
  parameter int P   = 5,
  parameter int OFF = 3
) (
  input  logic            i_clk,
  input  logic            i_rst_n,
  turbo_encoder_if.slave  bus
);
  localparam int CW = $clog2(K);
  localparam int IW = CW + 1;
  localparam logic [CW-1:0] LAST_N = CW'(K - 1);
  localparam logic [CW-1:0] OFF_N  = CW'(OFF);
  localparam logic [CW-1:0] TWO    = CW'(2);
  localparam logic [IW-1:0] P_W    = IW'(P);
  localparam logic [IW-1:0] K_W    = IW'(K);

  typedef enum logic [2:0] {IDLE, LOAD, ENC, TAIL1, TAIL2} state_t;

  state_t          state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [CW-1:0]   idx_q, idx_d;
  logic [2:0]      s1_q, s1_d;
  logic [2:0]      s2_q, s2_d;
  logic [K-1:0]    buf_q, buf_d;
  logic            done_q, done_d;
  logic            u1, u2, a1, a2, p1, p2, fire;
  logic [IW-1:0]   idx_sum, idx_wrap;

  // Outside ENC the feedback bit is fed back as input, which forces a=0 and flushes the trellis.
  assign u1       = (state_q == ENC) ? buf_q[cnt_q] : s1_q[1] ^ s1_q[0];
  assign u2       = (state_q == ENC) ? buf_q[idx_q] : s2_q[1] ^ s2_q[0];
  assign a1       = u1 ^ s1_q[1] ^ s1_q[0];
  assign a2       = u2 ^ s2_q[1] ^ s2_q[0];
  assign p1       = a1 ^ s1_q[2] ^ s1_q[0];
  assign p2       = a2 ^ s2_q[2] ^ s2_q[0];
  assign idx_sum  = {1'b0, idx_q} + P_W;
  assign idx_wrap = idx_sum - K_W;
  assign fire     = bus.o_valid & bus.i_ready;

  assign bus.o_ready = state_q == LOAD;
  assign bus.o_valid = state_q inside {ENC, TAIL1, TAIL2};
  assign bus.o_tail  = state_q inside {TAIL1, TAIL2};
  assign bus.o_last  = (state_q == TAIL2) && (cnt_q == TWO);
  assign bus.o_done  = done_q;
  assign bus.o_code  = (state_q == ENC)   ? {p2, p1, u1} :
                       (state_q == TAIL1) ? {1'b0, p1, u1} :
                       (state_q == TAIL2) ? {p2, 1'b0, u2} : 3'b000;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    idx_d   = idx_q;
    s1_d    = s1_q;
    s2_d    = s2_q;
    buf_d   = buf_q;
    done_d  = 1'b0;
    case (state_q)
      IDLE: if (bus.i_start) begin
        state_d = LOAD;
        cnt_d   = '0;
        s1_d    = '0;
        s2_d    = '0;
      end
      LOAD: if (bus.i_valid) begin
        buf_d[cnt_q] = bus.i_bit;
        cnt_d        = cnt_q + 1'b1;
        if (cnt_q == LAST_N) begin
          state_d = ENC;
          cnt_d   = '0;
          idx_d   = OFF_N;
        end
      end
      ENC: if (fire) begin
        s1_d  = {a1, s1_q[2:1]};
        s2_d  = {a2, s2_q[2:1]};
        cnt_d = cnt_q + 1'b1;
        idx_d = (idx_sum >= K_W) ? idx_wrap[CW-1:0] : idx_sum[CW-1:0];
        if (cnt_q == LAST_N) begin
          state_d = TAIL1;
          cnt_d   = '0;
        end
      end
      TAIL1: if (fire) begin
        s1_d  = {a1, s1_q[2:1]};
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == TWO) begin
          state_d = TAIL2;
          cnt_d   = '0;
        end
      end
      TAIL2: if (fire) begin
        s2_d  = {a2, s2_q[2:1]};
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == TWO) begin
          state_d = IDLE;
          cnt_d   = '0;
          done_d  = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      idx_q   <= '0;
      s1_q    <= '0;
      s2_q    <= '0;
      buf_q   <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      s1_q    <= s1_d;
      s2_q    <= s2_d;
      buf_q   <= buf_d;
      done_q  <= done_d;
    end
  end
endmodule
